// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared word type and width helpers for the systolic array edge buffers
package systola_pkg;

    localparam int WORDLEN_DEF = 8;

    typedef logic [WORDLEN_DEF-1:0] lane_word_t;

    // Pointer width for a ring of 'depth' entries; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/skew_inbuf_lane.sv
// rtl/skew_inbuf_lane.sv - one lane of the skewing input FIFO: storage, pointers, pad and occupancy
module skew_inbuf_lane
    import systola_pkg::*;
#(
    parameter int WORDLEN  = WORDLEN_DEF,
    parameter int DEPTH    = 16,
    parameter int PAD_INIT = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               reskew,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WORDLEN-1:0] din_i,
    output logic [WORDLEN-1:0] dout_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] PAD_RST  = CW'(PAD_INIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WORDLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      pad_q, pad_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic               pop_act;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Pads are consumed before real data; a pop on an empty lane is ignored.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        pad_d   = pad_q;
        pop_act = pop_i && (occ_q != '0);
        if (pop_act) begin
            if (pad_q != '0) begin
                pad_d = pad_q - 1'b1;
            end else begin
                head_d = next_ptr(head_q);
            end
        end
        if (push_i) begin
            tail_d = next_ptr(tail_q);
        end
        occ_d = occ_q + CW'(push_i) - CW'(pop_act);
    end

    // Control state; reskew reloads the same values as reset.
    always_ff @(posedge clk) begin
        if (!rstn || reskew) begin
            head_q <= '0;
            tail_q <= '0;
            pad_q  <= PAD_RST;
            occ_q  <= PAD_RST;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            pad_q  <= pad_d;
            occ_q  <= occ_d;
        end
    end

    // Word storage is never cleared; stale words are masked by occupancy.
    always_ff @(posedge clk) begin
        if (rstn && !reskew && push_i) begin
            mem_q[tail_q] <= din_i;
        end
    end

    assign dout_o  = (pad_q != '0) ? '0 : ((occ_q != '0) ? mem_q[head_q] : '0);
    assign empty_o = (occ_q == '0);
    assign full_o  = (occ_q == CNT_FULL);

endmodule

// File: rtl/skew_inbuf.sv
// rtl/skew_inbuf.sv - diagonally pre-skewed multi-lane input FIFO (optional error flags: SKEW_INBUF_ERR_EN)
module skew_inbuf
    import systola_pkg::*;
#(
    parameter int NLANES  = 4,
    parameter int WORDLEN = WORDLEN_DEF,
    parameter int DEPTH   = 16,
    parameter int SKEW    = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      reskew,
    input  logic                      wr_en,
    input  logic [NLANES*WORDLEN-1:0] din,
    output logic                      wr_ready,
    input  logic                      rd_en,
    output logic [NLANES*WORDLEN-1:0] dout,
    output logic [NLANES-1:0]         empty,
    output logic [NLANES-1:0]         full,
    output logic                      all_empty,
    output logic                      ovf_err,
    output logic                      udf_err
);

    logic push;

    // Writes are all-or-nothing: one full lane blocks every lane.
    assign wr_ready  = ~|full;
    assign push      = wr_en & wr_ready;
    assign all_empty = &empty;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        skew_inbuf_lane #(
            .WORDLEN  (WORDLEN),
            .DEPTH    (DEPTH),
            .PAD_INIT (i * SKEW)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .reskew  (reskew),
            .push_i  (push),
            .pop_i   (rd_en),
            .din_i   (din[i*WORDLEN +: WORDLEN]),
            .dout_o  (dout[i*WORDLEN +: WORDLEN]),
            .empty_o (empty[i]),
            .full_o  (full[i])
        );
    end

`ifdef SKEW_INBUF_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky misuse flags; only reset clears them, reskew leaves them alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && !wr_ready) ovf_q <= 1'b1;
            if (rd_en && all_empty) udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_skew_inbuf.sv
// tb/tb_skew_inbuf.sv - randomized self-checking bench for skew_inbuf against a queue model
module tb_skew_inbuf;
    import systola_pkg::*;

    localparam int NLANES  = 4;
    localparam int WORDLEN = 8;
    localparam int DEPTH   = 8;
    localparam int SKEW    = 1;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      reskew;
    logic                      wr_en;
    logic                      rd_en;
    logic [NLANES*WORDLEN-1:0] din;
    logic                      wr_ready;
    logic [NLANES*WORDLEN-1:0] dout;
    logic [NLANES-1:0]         empty;
    logic [NLANES-1:0]         full;
    logic                      all_empty;
    logic                      ovf_err;
    logic                      udf_err;

    int checks   = 0;
    int failures = 0;

    // Each lane is a plain queue; skew padding is simply leading zero words.
    lane_word_t mq [NLANES][$];
    bit         m_ovf;
    bit         m_udf;

    skew_inbuf #(
        .NLANES  (NLANES),
        .WORDLEN (WORDLEN),
        .DEPTH   (DEPTH),
        .SKEW    (SKEW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .reskew    (reskew),
        .wr_en     (wr_en),
        .din       (din),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .all_empty (all_empty),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_all_empty();
        for (int i = 0; i < NLANES; i++) if (mq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        for (int i = 0; i < NLANES; i++) if (mq[i].size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reload();
        for (int i = 0; i < NLANES; i++) begin
            mq[i].delete();
            for (int k = 0; k < i * SKEW; k++) mq[i].push_back('0);
        end
    endfunction

    task automatic compare_all();
        logic [NLANES*WORDLEN-1:0] e_dout;
        logic [NLANES-1:0]         e_empty;
        logic [NLANES-1:0]         e_full;
        for (int i = 0; i < NLANES; i++) begin
            e_dout[i*WORDLEN +: WORDLEN] = (mq[i].size() > 0) ? mq[i][0] : '0;
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEPTH);
        end
        check("dout",      32'(dout),      32'(e_dout));
        check("empty",     32'(empty),     32'(e_empty));
        check("full",      32'(full),      32'(e_full));
        check("wr_ready",  32'(wr_ready),  32'(model_ready()));
        check("all_empty", 32'(all_empty), 32'(model_all_empty()));
`ifdef SKEW_INBUF_ERR_EN
        check("ovf_err",   32'(ovf_err),   32'(m_ovf));
        check("udf_err",   32'(udf_err),   32'(m_udf));
`else
        check("ovf_err",   32'(ovf_err),   32'd0);
        check("udf_err",   32'(udf_err),   32'd0);
`endif
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit rn, input bit wr, input bit rd, input bit rs,
                         input logic [NLANES*WORDLEN-1:0] d);
        bit rdy;
        bit ae;
        rstn   = rn;
        wr_en  = wr;
        rd_en  = rd;
        reskew = rs;
        din    = d;
        #4;
        compare_all();
        if (!rn) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
            model_reload();
        end else begin
            rdy = model_ready();
            ae  = model_all_empty();
            if (wr && !rdy) m_ovf = 1'b1;
            if (rd && ae)   m_udf = 1'b1;
            if (rs) begin
                model_reload();
            end else begin
                for (int i = 0; i < NLANES; i++) begin
                    if (rd && mq[i].size() > 0) void'(mq[i].pop_front());
                    if (wr && rdy) mq[i].push_back(d[i*WORDLEN +: WORDLEN]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NLANES*WORDLEN-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [7:0] k8;
        int         guard;
        rstn = 1'b0; reskew = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        model_reload();
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);

        // Diagonal skew: four parallel writes then drain.
        check("rst_empty", 32'(empty), 32'b0001);
        check("rst_dout",  32'(dout),  32'd0);
        for (int k = 1; k <= 4; k++) begin
            k8 = 8'(k);
            cycle(1, 1, 0, 0, {4{k8}});
        end
        for (int c = 0; c < 7; c++) cycle(1, 0, 1, 0, '0);

        // Fill until lane 3 is full, then an overflowing write.
        cycle(0, 0, 0, 0, '0);
        for (int c = 0; c < 5; c++) cycle(1, 1, 0, 0, rnd_word());
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_full3",    32'(full[3]),  32'd1);
        cycle(1, 1, 0, 0, rnd_word());
`ifdef SKEW_INBUF_ERR_EN
        check("fill_ovf", 32'(ovf_err), 32'd1);
`else
        check("fill_ovf", 32'(ovf_err), 32'd0);
`endif

        // Full lane with read and write together: write refused.
        cycle(1, 1, 1, 0, rnd_word());
        check("fullrw_wr_ready", 32'(wr_ready), 32'd1);

        // Mid-stream reskew together with a write.
        cycle(1, 1, 1, 0, rnd_word());
        cycle(1, 1, 0, 1, rnd_word());
        check("reskew_empty", 32'(empty), 32'b0001);
        check("reskew_dout",  32'(dout),  32'd0);

        // Random traffic: wraps, full/empty edges, occasional reskew/reset.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 49) == 0),
                  rnd_word());
        end

        // Drain, underflow read, then a reskew must not clear udf_err.
        guard = 0;
        while (!model_all_empty() && guard < 64) begin
            cycle(1, 0, 1, 0, '0);
            guard++;
        end
        check("drain_bound", 32'(model_all_empty()), 32'd1);
        cycle(1, 0, 1, 0, '0);
        check("udf_dout", 32'(dout), 32'd0);
        cycle(1, 0, 0, 1, '0);
`ifdef SKEW_INBUF_ERR_EN
        check("udf_sticky", 32'(udf_err), 32'd1);
`else
        check("udf_sticky", 32'(udf_err), 32'd0);
`endif
        cycle(1, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skew_inbuf.md
# skew_inbuf

Multi-lane circular input FIFO feeding the west/north edge of the PE array. It holds NLANES parallel word streams and pre-skews them diagonally: lane i starts with i*SKEW zero entries, so one parallel write per cycle leaves the array correctly staggered. It adds full/empty protection, a re-skew command for back-to-back tiles, and optional sticky error flags.

## Interface
- NLANES, 4: number of lanes (array rows or columns)
- WORDLEN, 8: bits per word
- DEPTH, 16: entries per lane, 2..64; must satisfy (NLANES-1)*SKEW <= DEPTH
- SKEW, 1: zero entries added per lane index
- clk  in  1  clock, all logic on posedge
- rstn  in  1  synchronous active-low reset
- reskew  in  1  discard all lane contents and reload skew padding
- wr_en  in  1  push one word into every lane
- din  in  NLANES*WORDLEN  lane i at bits [i*WORDLEN +: WORDLEN]
- wr_ready  out  1  no lane full; a write is accepted only when wr_en & wr_ready
- rd_en  in  1  pop the head of every non-empty lane
- dout  out  NLANES*WORDLEN  lane heads; 0 for empty or padding entries
- empty  out  NLANES  per-lane occupancy == 0
- full  out  NLANES  per-lane occupancy == DEPTH
- all_empty  out  1  &empty
- ovf_err, udf_err  out  1 each  sticky error flags (see Configuration)

## Operation
- Each lane: storage DEPTH x WORDLEN, head and tail pointers of $clog2(DEPTH) bits, pad counter and occupancy counter of $clog2(DEPTH+1) bits. Occupancy = pad + stored data.
- Reset (rstn=0) or reskew=1: head=tail=0; lane i pad=occ=i*SKEW; error flags cleared by reset only. reskew has priority over wr_en/rd_en in the same cycle, and storage contents are not cleared.
- Head selection: if pad>0 then dout lane = 0, else if occ>0 then storage[head], else 0.
- Pop (rd_en, lane not empty): if pad>0, pad decrements; otherwise head advances. occ decrements. rd_en on an empty lane has no effect on that lane; the other lanes still pop.
- Push (wr_en & wr_ready): storage[tail]<=din lane; tail advances; occ increments. Pushes are all-or-nothing: if any lane is full, no lane is written.
- Pointer wrap: pointer == DEPTH-1 advances to 0. DEPTH need not be a power of 2.
- Simultaneous push and pop on a lane: occ unchanged; both pointers move.
- Full lane with rd_en and wr_en together: the write is refused, because wr_ready is derived from the current-cycle full state with no bypass.
- Empty lane with rd_en and wr_en together: dout=0 this cycle, the pop is ignored, and the word appears at dout next cycle.

## Timing
- dout, empty, full, wr_ready and all_empty are combinational from registered state. Read latency is 0: the head is visible in the same cycle it is popped.
- A write becomes visible at dout of an empty lane 1 cycle after acceptance.
- After reset, before any traffic: dout=0; empty[0]=1 and empty[i>0]=(i*SKEW==0); full[i]=(i*SKEW==DEPTH); wr_ready=~|full; ovf_err=udf_err=0.
- After reskew, the post-reset values hold from the next cycle.

## Configuration
- SKEW_INBUF_ERR_EN defined: ovf_err sets on wr_en & ~wr_ready. udf_err sets on rd_en & all_empty. Both stay set until rstn=0; reskew does not clear them.
- SKEW_INBUF_ERR_EN undefined: ovf_err and udf_err are tied to 0, with no flag registers. All other behaviour is identical.

## Structure
- Shared package systola_pkg holds:
  - default WORDLEN;
  - a lane word typedef;
  - a localparam function for pointer width and count width.
- Sub-module skew_inbuf_lane holds one lane: storage, pointers, pad counter and occupancy, with the initial pad as a parameter.
- The top level generates NLANES lane instances, plus the wr_ready reduction, all_empty and the error flags.

## Test plan
Bench parameters: NLANES=4, WORDLEN=8, DEPTH=8, SKEW=1.
- Reset, then wr_en for 4 cycles with din lanes = {k,k,k,k}, k=1..4, then rd_en each cycle. Lane 0 yields 1,2,3,4; lane 3 yields 0,0,0,1,2,3,4. Diagonal skew confirmed.
- Fill until lane 3 is full (5 writes). wr_ready=0, and a 6th wr_en writes no lane. ovf_err=1 with the macro defined, 0 without it.
- Write 20 words with interleaved rd_en. Checks pointer wrap at 7->0, data order intact on all lanes, and no stale data.
- Lane full with rd_en and wr_en in the same cycle: write refused, occupancy drops by 1, and wr_ready=1 next cycle.
- Mid-stream reskew asserted together with wr_en=1. Next cycle: occ = {0,1,2,3}, dout=0, empty=4'b0001. The wr_en in that cycle is discarded.
- rd_en with all_empty=1 after draining: no state change, dout=0. udf_err=1 and it stays set through a following reskew.
